mul_vector_seq: RTL
===================

// Module: mul_vector_seq
// PURPOSE
//  Sequential bit-sliced vector multiplier, the parametrised successor of the fixed 2x2-bit combinational mul4 vector block.
//  Each operand bit i is a LANES-wide word; bit k of that word belongs to lane k, so LANES independent products run in parallel.
//  Shift-add over OP_W cycles, driven by valid/ready handshakes in and out, with an unsigned/signed mode per transaction.
//  Sits between the vector stimulus source and the fitness/compare stage.
// PARAMETERS
//  OP_W   2   operand width in bits (bit planes per operand), >=2
//  LANES  16  parallel lanes (width of each bit plane), >=1
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              a, b and sgn are valid
//  in_ready   out  1              block accepts a new operand set
//  sgn        in   1              1 = two's-complement operands, 0 = unsigned
//  a          in   OP_W x LANES   a[i][k] = bit i of lane k operand A
//  b          in   OP_W x LANES   b[i][k] = bit i of lane k operand B
//  out_valid  out  1              y holds a finished product
//  out_ready  in   1              consumer takes y
//  y          out  2*OP_W x LANES y[i][k] = bit i of lane k product
//  busy       out  1              FSM is not in IDLE
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
//  - Reset: state=IDLE, out_valid=0, y=0, busy=0. in_ready=1 from the first cycle after rst is deasserted.
//  - FSM states: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready:
//    - latch a and b, sign- or zero-extended to 2*OP_W planes per the latched sgn;
//    - clear acc and set j=0, then go to CALC.
//  - CALC, one multiplier bit j per cycle: pp = (A_ext << j) masked lane-wise by b[j].
//    - acc += pp for j < OP_W-1.
//    - At j = OP_W-1: acc -= pp if sgn, else acc += pp.
//    - Subtract is implemented as acc + ~pp + 1.
//  - After the j = OP_W-1 step, go to DONE with y=acc and out_valid=1.
//  - Arithmetic is modulo 2^(2*OP_W) per lane. Lanes never interact; no carry crosses lanes.
//  - Latency: accept at edge T; out_valid=1 after edge T+OP_W.
//  - DONE: y and out_valid stay stable while out_ready=0. in_ready=0 and new inputs are ignored.
//  - On out_valid&out_ready: out_valid=0, return to IDLE. y keeps its last value until the next DONE.
//    - Minimum issue interval is OP_W+2 cycles.
//  - in_ready is 0 in CALC and DONE. in_valid there has no effect.
//  - Reset in any state, including mid-CALC or DONE with out_ready=0:
//    - the next cycle shows reset values and the partial result is discarded;
//    - rst has priority over every handshake in the same cycle.
//  - Inputs are sampled only on the accept edge. Changing a, b or sgn afterwards has no effect.
// STRUCTURE
//  - Package mul_vec_pkg holds:
//    - typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
//    - a function sext_planes(): plane replication for sign extension.
//  - Sub-module bitslice_add #(W, LANES): adds two W-plane vectors plus a carry-in word.
//    - Ripple carry across planes using plane-wide &, ^, |.
//    - Purely combinational; instantiated once for add/subtract.
//  - Counter j is $clog2(OP_W)+1 bits wide.
// TESTING (OP_W=2, LANES=16)
//  1. Exhaustive unsigned: a1=FF00 a0=F0F0 b1=CCCC b0=AAAA sgn=0 -> y3=8000 y2=4C00 y1=6AC0 y0=A0A0.
//  2. Signed: all lanes a=-1,b=-1 (all FFFF) sgn=1 -> y0=FFFF, y3..y1=0000; a=-2,b=-2 (a1=b1=FFFF, a0=b0=0) -> y2=FFFF, rest 0.
//  3. Unsigned 3*3 all lanes (all FFFF, sgn=0) -> y3=FFFF y2=0000 y1=0000 y0=FFFF; out_valid exactly 2 edges after accept.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> y and out_valid unchanged, in_ready=0; in_valid pulses ignored.
//  5. Reset mid-CALC (rst high on the first CALC cycle) -> next cycle out_valid=0, y=0, busy=0; in_ready=1 once rst drops.
//  6. Back-to-back: test 1 then test 3, out_ready tied 1 -> both results correct in order, issue interval 4 cycles.

Source files
------------

// File: rtl/mul_vec_pkg.sv
// ----------------------------------------------------------------------------
// mul_vec_pkg: shared types and helpers for the bit-sliced vector multiplier.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mul_vec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fill bit replicated into every extension plane of one lane.
    function automatic logic sext_planes(input logic msb, input logic sgn);
        return msb & sgn;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitslice_add.sv
// ----------------------------------------------------------------------------
// bitslice_add: lane-parallel ripple adder over W bit planes plus carry-in word.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bitslice_add #(
    parameter int W     = 4,
    parameter int LANES = 16
) (
    input  logic [W-1:0][LANES-1:0] x,
    input  logic [W-1:0][LANES-1:0] y,
    input  logic [LANES-1:0]        cin,
    output logic [W-1:0][LANES-1:0] sum
);

    logic [LANES-1:0] carry;

    // Each bit of a plane is a different lane, so carries move only between planes.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int p = 0; p < W; p++) begin
            sum[p] = x[p] ^ y[p] ^ carry;
            carry  = (x[p] & y[p]) | (carry & (x[p] ^ y[p]));
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_vector_seq.sv
// ----------------------------------------------------------------------------
// mul_vector_seq: sequential shift-add multiplier, LANES products in parallel.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mul_vector_seq
    import mul_vec_pkg::*;
#(
    parameter int OP_W  = 2,
    parameter int LANES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         sgn,
    input  logic [OP_W-1:0][LANES-1:0]   a,
    input  logic [OP_W-1:0][LANES-1:0]   b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*OP_W-1:0][LANES-1:0] y,
    output logic                         busy
);

    localparam int PW = 2 * OP_W;
    localparam int CW = $clog2(OP_W) + 1;

    state_t                     state;
    state_t                     state_nx;
    logic [CW-1:0]              j;
    logic [PW-1:0][LANES-1:0]   a_ext;
    logic [PW-1:0][LANES-1:0]   a_in_ext;
    logic [PW-1:0][LANES-1:0]   acc;
    logic [PW-1:0][LANES-1:0]   shifted;
    logic [PW-1:0][LANES-1:0]   addend;
    logic [PW-1:0][LANES-1:0]   sum;
    logic [OP_W-1:0][LANES-1:0] b_lat;
    logic                       sgn_lat;
    logic [LANES-1:0]           b_sel;
    logic [LANES-1:0]           cin;
    logic                       last;
    logic                       sub;
    logic                       accept;
    logic                       deliver;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        accept   = in_valid & in_ready;
        deliver  = out_valid & out_ready;
        last     = (j == CW'(OP_W - 1));
        state_nx = state;
        case (state)
            IDLE:    if (accept)  state_nx = CALC;
            CALC:    if (last)    state_nx = DONE;
            DONE:    if (deliver) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        a_in_ext = '0;
        for (int p = 0; p < PW; p++) begin
            if (p < OP_W) begin
                a_in_ext[p] = a[p];
            end else begin
                for (int k = 0; k < LANES; k++) begin
                    a_in_ext[p][k] = sext_planes(a[OP_W-1][k], sgn);
                end
            end
        end
    end

    // Shifting the packed plane vector by whole planes moves every lane at once.
    always_comb begin
        shifted = a_ext << (32'(j) * LANES);
        b_sel   = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (j == CW'(i)) b_sel = b_lat[i];
        end
        sub    = sgn_lat & last;
        cin    = {LANES{sub}};
        addend = '0;
        for (int p = 0; p < PW; p++) begin
            addend[p] = (shifted[p] & b_sel) ^ {LANES{sub}};
        end
    end

    bitslice_add #(
        .W     (PW),
        .LANES (LANES)
    ) u_add (
        .x   (acc),
        .y   (addend),
        .cin (cin),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            acc       <= '0;
            j         <= '0;
            a_ext     <= '0;
            b_lat     <= '0;
            sgn_lat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_ext   <= a_in_ext;
                        b_lat   <= b;
                        sgn_lat <= sgn;
                        acc     <= '0;
                        j       <= '0;
                    end
                end
                CALC: begin
                    acc <= sum;
                    j   <= j + 1'b1;
                    if (last) begin
                        y         <= sum;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (deliver) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
